// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer slice.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } fetch_state_t;

  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_out_buffer.sv
// Decode-facing output register: loads a fetched instruction, holds it under stall, drops it on flush.
module fetch_out_buffer
  import fetch_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              flush,
  input  logic              stall,
  input  logic [INST_W-1:0] load_inst,
  input  logic [XLEN-1:0]   load_pc,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc
);

  // Flush wins over load; payload is left untouched when only the valid bit drops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else if (flush) begin
      inst_valid <= 1'b0;
    end else if (load) begin
      inst_valid <= 1'b1;
      inst       <= load_inst;
      inst_pc    <= load_pc;
    end else if (!stall) begin
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC owner and single-outstanding imem request sequencer with redirect squashing.
// Optional build macro: FETCH_MISALIGN_TRAP_EN (misaligned redirects trap and halt fetch).
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              stall,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic              misalign_trap,
`endif
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc
);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] redirect_target;
  logic            redirect_misalign;
  logic            redirect_take;
  logic            halted;
  logic            halted_next;
  logic            req_fire;
  logic            rsp_load;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redirect_target   = redirect_pc;

  // A misaligned redirect parks fetch until an aligned redirect arrives.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      halted        <= 1'b0;
      misalign_trap <= 1'b0;
    end else begin
      halted        <= halted_next;
      misalign_trap <= redirect_misalign;
    end
  end
`else
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_misalign    = 1'b0;
  assign redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
  assign halted               = 1'b0;
`endif

  assign redirect_take = redirect_valid && !redirect_misalign;
  assign imem_req_addr = fetch_pc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_next;
      if (redirect_take) begin
        fetch_pc <= redirect_target;
      end else if (rsp_load) begin
        fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      end
    end
  end

  // A request accepted before a redirect is still owed a response, hence S_DROP.
  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    req_fire       = 1'b0;
    rsp_load       = 1'b0;
    halted_next    = halted;
    if (redirect_misalign) begin
      halted_next = 1'b1;
    end else if (redirect_take) begin
      halted_next = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (!halted_next) begin
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        imem_req_valid = !(inst_valid && stall);
        req_fire       = imem_req_valid && imem_req_ready;
        if (redirect_valid) begin
          if (req_fire) begin
            state_next = S_DROP;
          end else if (halted_next) begin
            state_next = S_IDLE;
          end else begin
            state_next = S_REQ;
          end
        end else if (req_fire) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          if (!imem_rsp_valid) begin
            state_next = S_DROP;
          end else if (halted_next) begin
            state_next = S_IDLE;
          end else begin
            state_next = S_REQ;
          end
        end else if (imem_rsp_valid) begin
          rsp_load   = 1'b1;
          state_next = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) begin
          state_next = halted_next ? S_IDLE : S_REQ;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  fetch_out_buffer #(
    .XLEN(XLEN)
  ) u_out_buffer (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (rsp_load),
    .flush     (redirect_valid),
    .stall     (stall),
    .load_inst (imem_rsp_data),
    .load_pc   (fetch_pc),
    .inst_valid(inst_valid),
    .inst      (inst),
    .inst_pc   (inst_pc)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; covers FETCH_MISALIGN_TRAP_EN when defined.
module tb_fetch_sequencer;

  localparam logic [31:0] I0  = 32'h0000_0013;
  localparam logic [31:0] I1  = 32'h0010_0093;
  localparam logic [31:0] I2  = 32'h0020_0113;
  localparam logic [31:0] I3  = 32'h0030_0193;
  localparam logic [31:0] I4  = 32'h0040_0213;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  logic        clock;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int tests_run;
  int tests_failed;

  fetch_sequencer #(
    .XLEN    (64),
    .RESET_PC(64'h0)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign_trap (misalign_trap),
`endif
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic rdy, input logic rsp_v, input logic [31:0] rsp_d,
                               input logic redir_v, input logic [63:0] redir_pc, input logic stl);
    imem_req_ready = rdy;
    imem_rsp_valid = rsp_v;
    imem_rsp_data  = rsp_d;
    redirect_valid = redir_v;
    redirect_pc    = redir_pc;
    stall          = stl;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    #3;
    checkOutput("reset_inst_valid", 64'(inst_valid), 64'h0);
    checkOutput("reset_inst", 64'(inst), 64'h0);
    checkOutput("reset_inst_pc", inst_pc, 64'h0);
    checkOutput("reset_req_valid", 64'(imem_req_valid), 64'h0);
    checkOutput("reset_req_addr", imem_req_addr, 64'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    checkOutput("reset_trap", 64'(misalign_trap), 64'h0);
`endif
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick();

    // Sequential fetch: accept, one idle wait cycle, response.
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("seq0_req_valid", 64'(imem_req_valid), 64'h1);
    checkOutput("seq0_req_addr", imem_req_addr, 64'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("seq0_wait_no_req", 64'(imem_req_valid), 64'h0);
    tick();
    applyStimulus(0, 1, I0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("seq0_inst_valid", 64'(inst_valid), 64'h1);
    checkOutput("seq0_inst", 64'(inst), 64'(I0));
    checkOutput("seq0_inst_pc", inst_pc, 64'h0);
    checkOutput("seq1_req_addr", imem_req_addr, 64'h4);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("seq1_inst_cleared", 64'(inst_valid), 64'h0);
    tick();
    applyStimulus(0, 1, I1, 0, 0, 0);
    tick();

    // Stall holds the presented instruction and blocks requests.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 1);
      checkOutput("stall_req_valid", 64'(imem_req_valid), 64'h0);
      checkOutput("stall_inst_valid", 64'(inst_valid), 64'h1);
      checkOutput("stall_inst", 64'(inst), 64'(I1));
      checkOutput("stall_inst_pc", inst_pc, 64'h4);
      tick();
    end
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("unstall_req_valid", 64'(imem_req_valid), 64'h1);
    checkOutput("unstall_req_addr", imem_req_addr, 64'h8);
    tick();

    // Redirect in S_WAIT, late response must be dropped.
    applyStimulus(0, 0, 0, 1, 64'h100, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("drop_no_req", 64'(imem_req_valid), 64'h0);
    checkOutput("drop_addr", imem_req_addr, 64'h100);
    tick();
    applyStimulus(0, 1, BAD, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("drop_discarded", 64'(inst_valid), 64'h0);
    checkOutput("redir_req_valid", 64'(imem_req_valid), 64'h1);
    checkOutput("redir_req_addr", imem_req_addr, 64'h100);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 1, I2, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("redir_inst", 64'(inst), 64'(I2));
    checkOutput("redir_inst_pc", inst_pc, 64'h100);
    checkOutput("redir_next_addr", imem_req_addr, 64'h104);
    tick();

    // Redirect coinciding with a response: discard, no S_DROP detour.
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 1, BAD, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("samecyc_inst_valid", 64'(inst_valid), 64'h0);
    checkOutput("samecyc_req_valid", 64'(imem_req_valid), 64'h1);
    checkOutput("samecyc_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 1, I3, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("wrap_inst_valid", 64'(inst_valid), 64'h1);
    checkOutput("wrap_inst", 64'(inst), 64'(I3));
    checkOutput("wrap_inst_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wrap_next_addr", imem_req_addr, 64'h0);
    tick();

`ifdef FETCH_MISALIGN_TRAP_EN
    applyStimulus(0, 0, 0, 1, 64'h102, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("trap_pulse", 64'(misalign_trap), 64'h1);
    checkOutput("trap_inst_valid", 64'(inst_valid), 64'h0);
    tick();
    checkOutput("trap_one_cycle", 64'(misalign_trap), 64'h0);
    applyStimulus(0, 1, BAD, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("halt_no_req0", 64'(imem_req_valid), 64'h0);
    tick();
    checkOutput("halt_no_req1", 64'(imem_req_valid), 64'h0);
    applyStimulus(1, 0, 0, 1, 64'h200, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("resume_req_valid", 64'(imem_req_valid), 64'h1);
    checkOutput("resume_req_addr", imem_req_addr, 64'h200);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 1, I4, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("resume_inst", 64'(inst), 64'(I4));
    checkOutput("resume_inst_pc", inst_pc, 64'h200);
`else
    applyStimulus(0, 0, 0, 1, 64'h1_0006, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("align_addr", imem_req_addr, 64'h1_0004);
    tick();
    applyStimulus(0, 1, BAD, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("align_req_valid", 64'(imem_req_valid), 64'h1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 1, I4, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("align_inst", 64'(inst), 64'(I4));
    checkOutput("align_inst_pc", inst_pc, 64'h1_0004);
`endif

    // Asynchronous reset mid-operation.
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_inst_valid", 64'(inst_valid), 64'h0);
    checkOutput("midrst_inst", 64'(inst), 64'h0);
    checkOutput("midrst_req_valid", 64'(imem_req_valid), 64'h0);
    checkOutput("midrst_addr", imem_req_addr, 64'h0);
    tick();
    reset_n = 1'b1;
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("postrst_req_valid", 64'(imem_req_valid), 64'h1);
    checkOutput("postrst_req_addr", imem_req_addr, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
